// File: rtl/int_sched_pkg.sv
// Shared encodings for the interrupt scheduler: FSM states, register map, id helpers.
package int_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } sched_state_t;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_SWTRIG  = 2'd3;

    localparam int unsigned IRQ_ID_NONE = 0;

    // Returns lowest set index + 1, or 0 when nothing is set.
    function automatic logic [5:0] lowest_id(input logic [31:0] v);
        lowest_id = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (v[i-1]) lowest_id = 6'(i);
        end
    endfunction

endpackage

// File: rtl/int_pending_bank.sv
// Rising-edge detector and pending latch for every interrupt source.
module int_pending_bank
    import int_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic [NUM_SRC-1:0] set_bits,
    input  logic [NUM_SRC-1:0] clr_bits,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] src_edge;

    assign src_edge = int_src & ~prev_src;

    // Loading prev_src during reset hides lines already high at release.
    always_ff @(posedge clk) begin
        prev_src <= int_src;
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_bits) | src_edge | set_bits;
        end
    end

endmodule

// File: rtl/int_scheduler.sv
// Fixed-priority interrupt scheduler with request/ack/EOI handshake and register port.
module int_scheduler
    import int_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 10,
    parameter int unsigned ID_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] int_src,
    input  logic               int_disable,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    input  logic [1:0]         reg_addr,
    input  logic               reg_we,
    input  logic               reg_re,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata
);

    sched_state_t       state, state_nxt;
    logic               req_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] w1c_bits;
    logic [NUM_SRC-1:0] sw_bits;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] cand;
    logic               arb_hit;
    logic [ID_W-1:0]    arb_id;
    logic [31:0]        status;
    logic [31:0]        rdata_nxt;

    if (NUM_SRC < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^reg_wdata[31:NUM_SRC];
    end

    assign cand    = pending & mask;
    assign arb_hit = !int_disable && (|cand);
    assign arb_id  = ID_W'(lowest_id(32'(cand)));

    assign w1c_bits = (reg_we && reg_addr == REG_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0;
    assign sw_bits  = (reg_we && reg_addr == REG_SWTRIG)  ? reg_wdata[NUM_SRC-1:0] : '0;

    always_comb begin
        ack_clr = '0;
        if (state == REQ && irq_ack) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (irq_id == ID_W'(i + 1)) ack_clr[i] = 1'b1;
            end
        end
    end

    int_pending_bank #(
        .NUM_SRC (NUM_SRC)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .int_src  (int_src),
        .set_bits (sw_bits),
        .clr_bits (w1c_bits | ack_clr),
        .pending  (pending)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask <= '1;
        end else if (reg_we && reg_addr == REG_MASK) begin
            mask <= reg_wdata[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= ID_W'(IRQ_ID_NONE);
        end else begin
            state   <= state_nxt;
            irq_req <= req_nxt;
            irq_id  <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_hit) state_nxt = REQ;
            REQ: begin
                if (irq_ack)          state_nxt = SERVICE;
                else if (int_disable) state_nxt = IDLE;
            end
            SERVICE: if (irq_eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack takes precedence over int_disable; masking in REQ does not withdraw.
    always_comb begin
        req_nxt = irq_req;
        id_nxt  = irq_id;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    req_nxt = 1'b1;
                    id_nxt  = arb_id;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    req_nxt = 1'b0;
                end else if (int_disable) begin
                    req_nxt = 1'b0;
                    id_nxt  = ID_W'(IRQ_ID_NONE);
                end
            end
            SERVICE: if (irq_eoi) id_nxt = ID_W'(IRQ_ID_NONE);
            default: begin
                req_nxt = 1'b0;
                id_nxt  = ID_W'(IRQ_ID_NONE);
            end
        endcase
    end

    assign status = {16'h0000, 8'(irq_id), 6'b000000, state};

    always_comb begin
        case (reg_addr)
            REG_MASK:    rdata_nxt = 32'(mask);
            REG_PENDING: rdata_nxt = 32'(pending);
            REG_STATUS:  rdata_nxt = status;
            default:     rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_rdata <= '0;
        end else if (reg_re) begin
            reg_rdata <= rdata_nxt;
        end
    end

endmodule
